mb32_r8enc_stage: RTL and testbench
===================================

Name: mb32_r8enc_stage

Overview:
- Front stage of the 2-stage radix-8 Booth multiplier pipeline; sits directly upstream of the partial-product/accumulate stage.
- Takes a multiplier mx and a multiplicand my.
- Produces per-group one-hot Booth selects (s/d/t/q = magnitude 1/2/3/4, n = negative), the multiplicand pass-through, and the precomputed triple multiple tmy = 3*my.
- Outputs are registered behind a valid/ready handshake with a 1-entry skid buffer, so in_ready has no combinational path from out_ready.

Parameters:
- WIDTH, 32, operand width in bits.
- SIGNED, 0, 0 = operands unsigned (zero-extended); 1 = two's complement (sign-extended).
- GROUP_CNT, (WIDTH>>2)+3, number of radix-8 digit groups (11 at WIDTH=32); must be >= ceil((WIDTH+1)/3).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  mx/my valid.
- in_ready  out  1  stage can accept an operand pair.
- mx  in  WIDTH  multiplier, Booth-recoded.
- my  in  WIDTH  multiplicand.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- s  out  GROUP_CNT  |digit|==1 per group.
- d  out  GROUP_CNT  |digit|==2.
- t  out  GROUP_CNT  |digit|==3.
- q  out  GROUP_CNT  |digit|==4.
- n  out  GROUP_CNT  digit<0.
- my_o  out  WIDTH  registered my.
- tmy  out  WIDTH+2  registered 3*my, extended per SIGNED.

Behaviour:
- Reset (RST=0, asynchronous):
  - Main register and skid register are cleared: out_valid=0, s/d/t/q/n=0, my_o=0, tmy=0, skid_valid=0.
  - in_ready=1 once reset is released.
- Extension: mx becomes xe[GROUP_CNT*3:0], with xe[-1]=0. Bits above WIDTH-1 are 0 (SIGNED=0) or copies of mx[WIDTH-1] (SIGNED=1).
- Digit decode: group i uses b3..b0 = xe[3i+2], xe[3i+1], xe[3i], xe[3i-1]. Digit value v = -4*b3 + 2*b2 + b1 + b0, range -4..+4.
- Select encoding:
  - At most one of s/d/t/q is set per group; none is set when v=0.
  - n=1 only when v<0. Both 0000 and 1111 give all zeros, including n=0.
- tmy = (my<<1) + my, computed at WIDTH+2 bits; my is zero- or sign-extended first.
- Latency: 1 cycle from an accepted input to out_valid when the output is not stalled.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
  - out_valid and the data bundle stay stable while out_valid && !out_ready.
- Skid buffer:
  - in_ready = !skid_valid, registered.
  - If an input is accepted while the main register holds data and out_ready=0, the new bundle goes into the skid register and in_ready drops the next cycle.
  - When the main register transfers, skid data (if any) moves into main and in_ready returns to 1.
  - Order is strictly FIFO. Maximum occupancy is 2 bundles.
- Simultaneous accept and transfer:
  - Main empty or transferring, skid empty: the new bundle loads main directly, with no bubble. Throughput is 1 per cycle while out_ready=1.
  - Skid full: in_ready=0, so no accept can occur.
- Reset asserted mid-operation: all in-flight bundles are discarded with no partial output. The first post-reset input behaves as after power-up.
- in_valid may drop without a transfer; the stage takes no action.
- mx/my are ignored when in_valid=0.

Decomposition:
- Shared package mb32_pkg:
  - GROUP_CNT derivation function.
  - Booth digit encode function: 4 bits -> {s,d,t,q,n}.
  - Extension helper for SIGNED.
  - The same package is used by the downstream stage.
- Sub-module r8_booth_digit_enc: combinational, 4-bit in, 5-bit one-hot out; instantiated GROUP_CNT times with a generate loop.
- The handshake and skid register logic stays in the top module.

Test Plan:
- SIGNED=0, mx=0x00000007, my=0x00000001, out_ready=1 -> 1 cycle later: s=11'h003, n=11'h001, d=t=q=0, tmy=34'h3.
- SIGNED=0, mx=0xFFFFFFFF, my=0xFFFFFFFF -> s=11'h001, n=11'h001, q=11'h400, tmy=34'h2_FFFF_FFFD.
- SIGNED=1, mx=0xFFFFFFFF, my=0xFFFFFFFF -> s=11'h001, n=11'h001, q=0, tmy=34'h3_FFFF_FFFD. Also mx=0x00000004 -> q=11'h001, n=11'h001, s=11'h002.
- Backpressure:
  - Stimulus: out_ready=0, push A then B on consecutive cycles, offer C.
  - Required: in_ready=0 the cycle after B is accepted; C is held off.
  - Then raise out_ready: A, B, C emerge in order on consecutive cycles with no loss or duplication.
- Streaming: out_ready=1, 100 random back-to-back inputs -> one output per cycle; the scoreboard reconstructs sum(v_i*8^i)==mx (extended) and checks tmy==3*my.
- Reset mid-operation: pulse RST low with two bundles buffered -> out_valid=0 and all outputs 0 immediately (asynchronous); in_ready=1 after release; the next input emerges after 1 cycle.

Source files
------------

// File: rtl/mb32_pkg.sv
// Shared definitions for the radix-8 Booth multiplier pipeline: group count,
// digit select encoding and operand extension helper.
package mb32_pkg;

  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_sel_t;

  function automatic int unsigned group_cnt(input int unsigned width);
    return (width >> 2) + 3;
  endfunction

  // b = {xe[3i+2], xe[3i+1], xe[3i], xe[3i-1]}; value = -4*b3 + 2*b2 + b1 + b0
  function automatic booth_sel_t booth_enc(input logic [3:0] b);
    booth_sel_t sel;
    sel = '0;
    case (b)
      4'b0001, 4'b0010: sel.s = 1'b1;
      4'b0011, 4'b0100: sel.d = 1'b1;
      4'b0101, 4'b0110: sel.t = 1'b1;
      4'b0111:          sel.q = 1'b1;
      4'b1000:          begin sel.q = 1'b1; sel.n = 1'b1; end
      4'b1001, 4'b1010: begin sel.t = 1'b1; sel.n = 1'b1; end
      4'b1011, 4'b1100: begin sel.d = 1'b1; sel.n = 1'b1; end
      4'b1101, 4'b1110: begin sel.s = 1'b1; sel.n = 1'b1; end
      default:          sel = '0;
    endcase
    return sel;
  endfunction

  function automatic logic ext_bit(input logic msb, input bit is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/mb32_r8enc_stage_if.sv
// Operand input and Booth-select output bundle of the radix-8 encode stage.
interface mb32_r8enc_stage_if
  import mb32_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned GROUP_CNT = group_cnt(WIDTH)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     mx;
  logic [WIDTH-1:0]     my;
  logic                 out_valid;
  logic                 out_ready;
  logic [GROUP_CNT-1:0] s;
  logic [GROUP_CNT-1:0] d;
  logic [GROUP_CNT-1:0] t;
  logic [GROUP_CNT-1:0] q;
  logic [GROUP_CNT-1:0] n;
  logic [WIDTH-1:0]     my_o;
  logic [WIDTH+1:0]     tmy;

  modport master (
    output in_valid, mx, my, out_ready,
    input  in_ready, out_valid, s, d, t, q, n, my_o, tmy
  );

  modport slave (
    input  in_valid, mx, my, out_ready,
    output in_ready, out_valid, s, d, t, q, n, my_o, tmy
  );
endinterface

// File: rtl/r8_booth_digit_enc.sv
// One radix-8 Booth digit: 4 overlapping multiplier bits to {s,d,t,q,n} selects.
module r8_booth_digit_enc
  import mb32_pkg::*;
(
  input  logic [3:0] grp,
  output logic [4:0] sel
);
  assign sel = booth_enc(grp);
endmodule

// File: rtl/mb32_r8enc_stage.sv
// Radix-8 Booth encode front stage: per-group digit selects plus 3*my, registered
// behind a valid/ready handshake with a one-entry skid buffer.
module mb32_r8enc_stage
  import mb32_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED    = 1'b0,
  parameter int unsigned GROUP_CNT = group_cnt(WIDTH)
) (
  input logic               CLK,
  input logic               RST,
  mb32_r8enc_stage_if.slave bus
);
  localparam int unsigned XW = 3 * GROUP_CNT + 1;
  localparam int unsigned BW = 5 * GROUP_CNT + 2 * WIDTH + 2;

  // xe[0] stands for the implicit zero below mx[0]
  logic [XW-1:0]        xe;
  logic [4:0]           sel_c [GROUP_CNT];
  logic [GROUP_CNT-1:0] s_c, d_c, t_c, q_c, n_c;
  logic [WIDTH+1:0]     my_ext, tmy_c;
  logic [BW-1:0]        bundle_c;
  logic [BW-1:0]        main_q, main_d, skid_q, skid_d;
  logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic                 accept, xfer;

  assign xe = {{(XW - WIDTH - 1){ext_bit(bus.mx[WIDTH-1], SIGNED)}}, bus.mx, 1'b0};

  for (genvar i = 0; i < GROUP_CNT; i++) begin : g_grp
    r8_booth_digit_enc u_enc (
      .grp (xe[3*i+3 -: 4]),
      .sel (sel_c[i])
    );
    assign s_c[i] = sel_c[i][4];
    assign d_c[i] = sel_c[i][3];
    assign t_c[i] = sel_c[i][2];
    assign q_c[i] = sel_c[i][1];
    assign n_c[i] = sel_c[i][0];
  end

  assign my_ext   = {{2{ext_bit(bus.my[WIDTH-1], SIGNED)}}, bus.my};
  assign tmy_c    = (my_ext << 1) + my_ext;
  assign bundle_c = {s_c, d_c, t_c, q_c, n_c, bus.my, tmy_c};

  assign accept = bus.in_valid & ~skid_valid_q;
  assign xfer   = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!main_valid_q || xfer) begin
      // Skid is drained first; in_ready is low whenever it is occupied.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = bundle_c;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = bundle_c;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign {bus.s, bus.d, bus.t, bus.q, bus.n, bus.my_o, bus.tmy} = main_q;

endmodule

// File: tb/tb_mb32_r8enc_stage.sv
// Scoreboard bench: unsigned and signed instances driven with identical stimulus,
// checked against an arithmetic radix-8 digit model.
module tb_mb32_r8enc_stage;
  localparam int unsigned W  = 32;
  localparam int unsigned GC = 11;

  typedef struct packed {
    logic [W-1:0] mx;
    logic [W-1:0] my;
  } txn_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt0 = 0;
  int   cnt1 = 0;
  txn_t sb0[$];
  txn_t sb1[$];

  mb32_r8enc_stage_if #(.WIDTH(W), .GROUP_CNT(GC)) bus0 ();
  mb32_r8enc_stage_if #(.WIDTH(W), .GROUP_CNT(GC)) bus1 ();

  mb32_r8enc_stage #(.WIDTH(W), .SIGNED(1'b0), .GROUP_CNT(GC)) u_dut0 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus0)
  );

  mb32_r8enc_stage #(.WIDTH(W), .SIGNED(1'b1), .GROUP_CNT(GC)) u_dut1 (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bitof(input longint x, input int k);
    if (k < 0) return 0;
    return int'((x >>> k) & 64'sd1);
  endfunction

  function automatic longint extend(input bit sgn, input logic [W-1:0] v);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  task automatic model(input bit sgn, input txn_t e,
                       output logic [GC-1:0] es, output logic [GC-1:0] ed,
                       output logic [GC-1:0] et, output logic [GC-1:0] eq,
                       output logic [GC-1:0] en, output logic [W+1:0] etmy);
    longint x, prod;
    int v, mag;
    x = extend(sgn, e.mx);
    for (int i = 0; i < GC; i++) begin
      v = -4 * bitof(x, 3*i+2) + 2 * bitof(x, 3*i+1) + bitof(x, 3*i) + bitof(x, 3*i-1);
      mag = (v < 0) ? -v : v;
      es[i] = (mag == 1);
      ed[i] = (mag == 2);
      et[i] = (mag == 3);
      eq[i] = (mag == 4);
      en[i] = (v < 0);
    end
    prod = 3 * extend(sgn, e.my);
    etmy = prod[W+1:0];
  endtask

  task automatic cmp(input string tag, input bit sgn, input txn_t e,
                     input logic [GC-1:0] s, input logic [GC-1:0] d, input logic [GC-1:0] t,
                     input logic [GC-1:0] q, input logic [GC-1:0] n,
                     input logic [W-1:0] my_o, input logic [W+1:0] tmy);
    logic [GC-1:0] es, ed, et, eq, en;
    logic [W+1:0]  etmy;
    longint sum;
    int v;
    model(sgn, e, es, ed, et, eq, en, etmy);
    chk({tag, ".s"}, 64'(s), 64'(es));
    chk({tag, ".d"}, 64'(d), 64'(ed));
    chk({tag, ".t"}, 64'(t), 64'(et));
    chk({tag, ".q"}, 64'(q), 64'(eq));
    chk({tag, ".n"}, 64'(n), 64'(en));
    chk({tag, ".my"}, 64'(my_o), 64'(e.my));
    chk({tag, ".tmy"}, 64'(tmy), 64'(etmy));
    sum = 0;
    for (int i = 0; i < GC; i++) begin
      v = s[i] ? 1 : d[i] ? 2 : t[i] ? 3 : q[i] ? 4 : 0;
      if (n[i]) v = -v;
      sum += longint'(v) * (longint'(1) << (3 * i));
    end
    chk({tag, ".recon"}, sum, extend(sgn, e.mx));
  endtask

  // Scoreboard push on every accepted operand pair
  always @(posedge clk) begin
    if (rst_n && bus0.in_valid && bus0.in_ready) sb0.push_back('{mx: bus0.mx, my: bus0.my});
    if (rst_n && bus1.in_valid && bus1.in_ready) sb1.push_back('{mx: bus1.mx, my: bus1.my});
  end

  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      cnt0++;
      if (sb0.size() == 0) chk("u0.unexpected", 64'd1, 64'd0);
      else cmp("u0", 1'b0, sb0.pop_front(), bus0.s, bus0.d, bus0.t, bus0.q, bus0.n,
               bus0.my_o, bus0.tmy);
    end
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      cnt1++;
      if (sb1.size() == 0) chk("u1.unexpected", 64'd1, 64'd0);
      else cmp("u1", 1'b1, sb1.pop_front(), bus1.s, bus1.d, bus1.t, bus1.q, bus1.n,
               bus1.my_o, bus1.tmy);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] mx, input logic [W-1:0] my);
    bus0.in_valid = v; bus0.mx = mx; bus0.my = my;
    bus1.in_valid = v; bus1.mx = mx; bus1.my = my;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [W-1:0] mx, input logic [W-1:0] my);
    drive(1'b1, mx, my);
    cyc();
    drive(1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic drain();
    set_ready(1'b1);
    drive(1'b0, '0, '0);
    for (int k = 0; k < 50 && (sb0.size() != 0 || sb1.size() != 0); k++) cyc();
    cyc();
    chk("drain.u0", 64'(sb0.size()), 64'd0);
    chk("drain.u1", 64'(sb1.size()), 64'd0);
  endtask

  initial begin
    int base0, bubbles;
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
    chk("rst.tmy", 64'(bus0.tmy | bus1.tmy), 64'd0);
    chk("rst.s", 64'(bus0.s | bus0.n | bus1.q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst.in_ready", 64'(bus0.in_ready & bus1.in_ready), 64'd1);

    // Directed cases with fixed expectations
    send1(32'h0000_0007, 32'h0000_0001);
    chk("d7.valid", 64'(bus0.out_valid), 64'd1);
    chk("d7.s", 64'(bus0.s), 64'h003);
    chk("d7.n", 64'(bus0.n), 64'h001);
    chk("d7.dtq", 64'(bus0.d | bus0.t | bus0.q), 64'd0);
    chk("d7.tmy", 64'(bus0.tmy), 64'h3);
    send1(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("dF.u.s", 64'(bus0.s), 64'h001);
    chk("dF.u.n", 64'(bus0.n), 64'h001);
    chk("dF.u.q", 64'(bus0.q), 64'h400);
    chk("dF.u.tmy", 64'(bus0.tmy), 64'h2_FFFF_FFFD);
    chk("dF.s.s", 64'(bus1.s), 64'h001);
    chk("dF.s.n", 64'(bus1.n), 64'h001);
    chk("dF.s.q", 64'(bus1.q), 64'h000);
    chk("dF.s.tmy", 64'(bus1.tmy), 64'h3_FFFF_FFFD);
    send1(32'h0000_0004, 32'h0000_0002);
    chk("d4.q", 64'(bus1.q), 64'h001);
    chk("d4.n", 64'(bus1.n), 64'h001);
    chk("d4.s", 64'(bus1.s), 64'h002);
    cyc();

    // Backpressure: A to main, B to skid, C held off
    set_ready(1'b0);
    drive(1'b1, 32'hA, 32'h11);
    cyc();
    drive(1'b1, 32'hB, 32'h22);
    cyc();
    chk("bp.in_ready", 64'(bus0.in_ready), 64'd0);
    drive(1'b1, 32'hC, 32'h33);
    cyc();
    cyc();
    chk("bp.held_ready", 64'(bus0.in_ready), 64'd0);
    chk("bp.stable", 64'(bus0.my_o), 64'h11);
    set_ready(1'b1);
    cyc();
    chk("bp.B", 64'(bus0.out_valid ? bus0.my_o : '0), 64'h22);
    cyc();
    drive(1'b0, '0, '0);
    chk("bp.C", 64'(bus0.out_valid ? bus0.my_o : '0), 64'h33);
    cyc();
    chk("bp.empty", 64'(bus0.out_valid), 64'd0);

    // Back-to-back streaming
    base0 = cnt0;
    bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom);
      cyc();
      if (!(bus0.out_valid && bus1.out_valid)) bubbles++;
    end
    drain();
    chk("stream.bubbles", 64'(bubbles), 64'd0);
    chk("stream.count", 64'(cnt0 - base0), 64'd100);

    // Random valid and backpressure
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom);
      set_ready($urandom_range(0, 2) != 0);
      cyc();
    end
    drain();

    // Reset with two bundles buffered
    set_ready(1'b0);
    drive(1'b1, $urandom, $urandom);
    cyc();
    drive(1'b1, $urandom, $urandom);
    cyc();
    drive(1'b0, '0, '0);
    chk("mrst.full", 64'(bus0.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    #1;
    chk("mrst.out_valid", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
    chk("mrst.data", 64'(bus0.s | bus0.n | bus1.t | bus1.n), 64'd0);
    chk("mrst.my_tmy", 64'(bus0.my_o | bus1.tmy), 64'd0);
    chk("mrst.in_ready", 64'(bus0.in_ready & bus1.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    send1(32'h1234_5678, 32'h0000_0055);
    chk("mrst.first", 64'(bus0.out_valid ? bus0.my_o : '0), 64'h55);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
